// File: rtl/cnt_ctrl_sched.sv
// cnt_ctrl_sched -- request scheduler in front of an external 16-bit up/down counter.
//
// Accepts single-cycle increment/decrement pulses, a level load request and a level
// "run to top" request paced by tick. It turns them into one-hot, registered strobes
// (up / dw / ld) for the counter. The counter value q is fed back and is used to
// decide when a run has reached the top band (q >= 16'hFFFC).
//
// Ports
//   clk       in   system clock, rising edge
//   greset_n  in   asynchronous active-low reset
//   up_req    in   increment pulse (pre edge-detected)
//   dw_req    in   decrement pulse
//   ld_req    in   load request (level)
//   run_req   in   run-to-top request (level)
//   tick      in   pacing strobe for run steps
//   din[15:0] in   load value
//   q[15:0]   in   counter value feedback
//   up        out  increment strobe
//   dw        out  decrement strobe
//   ld        out  load strobe
//   ld_val    out  load data, valid while ld=1
//   state     out  FSM state (00 IDLE, 01 RUN, 10 TOP, 11 LOAD)
//   busy      out  a request is pending, a strobe is out, or cooldown is active
//   drop      out  one-cycle pulse when a request is discarded
//
// Build option
//   CNT_CTRL_SAT_EN  when defined, up is withheld at q=FFFF and dw at q=0000; the request
//                    is discarded with a drop pulse. When it is undefined, the counter wraps.

module cnt_ctrl_sched (
  input  logic        clk,
  input  logic        greset_n,
  input  logic        up_req,
  input  logic        dw_req,
  input  logic        ld_req,
  input  logic        run_req,
  input  logic        tick,
  input  logic [15:0] din,
  input  logic [15:0] q,
  output logic        up,
  output logic        dw,
  output logic        ld,
  output logic [15:0] ld_val,
  output logic [1:0]  state,
  output logic        busy,
  output logic        drop
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] TOP  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  logic [1:0]  state_reg, state_next;
  logic        up_reg, up_next;
  logic        dw_reg, dw_next;
  logic        ld_reg, ld_next;
  logic [15:0] ld_val_reg, ld_val_next;
  logic        busy_reg, busy_next;
  logic        drop_reg, drop_next;
  logic        up_pend_reg, up_pend_next;
  logic        dw_pend_reg, dw_pend_next;

  logic q_top;
  logic cool;
  logic up_eff, dw_eff;
  logic serve_ok, serve_up, serve_dw, run_step;
  logic up_sat, dw_sat;

  // "q[15:2] all ones" is written as a magnitude compare. This keeps all of q in use
  // in builds without saturation, and synthesis reduces it to the same AND tree.
  assign q_top = (q >= 16'hFFFC);

  // Cooldown is the cycle right after an up/dw strobe. No separate register is needed
  // because the strobe registers already mark it. Reset clears it with them.
  assign cool = up_reg | dw_reg;

  // A pulse arriving this cycle is treated like an already-latched flag. This lets an
  // unblocked request reach its strobe one cycle later.
  assign up_eff = up_pend_reg | up_req;
  assign dw_eff = dw_pend_reg | dw_req;

`ifdef CNT_CTRL_SAT_EN
  assign up_sat = (q == 16'hFFFF);
  assign dw_sat = (q == 16'h0000);
`else
  assign up_sat = 1'b0;
  assign dw_sat = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (ld_req)                 state_next = LOAD;
        else if (run_req && !q_top) state_next = RUN;
        else                        state_next = IDLE;
      end
      RUN: begin
        if (ld_req)       state_next = LOAD;
        else if (!run_req) state_next = IDLE;
        else if (q_top)    state_next = TOP;
        else               state_next = RUN;
      end
      TOP: begin
        if (ld_req)                  state_next = LOAD;
        else if (!run_req || !q_top) state_next = IDLE;
        else                         state_next = TOP;
      end
      LOAD: begin
        state_next = ld_req ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    // A load request, or the LOAD state itself, blocks all up/dw service.
    // Cooldown also blocks it.
    serve_ok = (state_reg != LOAD) && !ld_req && !cool;
    serve_dw = serve_ok && dw_eff;
    serve_up = serve_ok && !dw_eff && up_eff;
    // A run step only takes a slot that nothing else wants. A blocked tick is lost.
    run_step = serve_ok && (state_reg == RUN) && run_req && !q_top && tick &&
               !up_eff && !dw_eff;

    up_next      = (serve_up && !up_sat) || run_step;
    dw_next      = serve_dw && !dw_sat;
    up_pend_next = up_eff && !serve_up;
    dw_pend_next = dw_eff && !serve_dw;
    drop_next    = (up_req && up_pend_reg) || (dw_req && dw_pend_reg) ||
                   (serve_up && up_sat) || (serve_dw && dw_sat);

    ld_next     = (state_next == LOAD);
    ld_val_next = ld_next ? din : ld_val_reg;

    // When a strobe is out now, the next cycle is a cooldown cycle and counts as busy.
    busy_next = up_pend_next || dw_pend_next || up_next || dw_next || ld_next || cool;
  end

  always_ff @(posedge clk or negedge greset_n) begin
    if (!greset_n) begin
      state_reg   <= IDLE;
      up_reg      <= 1'b0;
      dw_reg      <= 1'b0;
      ld_reg      <= 1'b0;
      ld_val_reg  <= 16'h0000;
      busy_reg    <= 1'b0;
      drop_reg    <= 1'b0;
      up_pend_reg <= 1'b0;
      dw_pend_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      up_reg      <= up_next;
      dw_reg      <= dw_next;
      ld_reg      <= ld_next;
      ld_val_reg  <= ld_val_next;
      busy_reg    <= busy_next;
      drop_reg    <= drop_next;
      up_pend_reg <= up_pend_next;
      dw_pend_reg <= dw_pend_next;
    end
  end

  assign up     = up_reg;
  assign dw     = dw_reg;
  assign ld     = ld_reg;
  assign ld_val = ld_val_reg;
  assign state  = state_reg;
  assign busy   = busy_reg;
  assign drop   = drop_reg;

endmodule

// File: tb/tb_cnt_ctrl_sched.sv
// Directed bench for cnt_ctrl_sched. A behavioural up/down counter closes the q loop.
// Expected strobes (kind, cycle, load value) are queued as stimulus is applied.
// A negedge monitor pops the queue and compares each strobe the DUT emits.
module tb_cnt_ctrl_sched;

  logic        clk = 1'b0;
  logic        greset_n = 1'b0;
  logic        up_req = 1'b0, dw_req = 1'b0, ld_req = 1'b0, run_req = 1'b0, tick = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [15:0] q_cnt = 16'h0000;
  logic        up, dw, ld, busy, drop;
  logic [15:0] ld_val;
  logic [1:0]  state;

  cnt_ctrl_sched dut (
    .clk(clk), .greset_n(greset_n), .up_req(up_req), .dw_req(dw_req),
    .ld_req(ld_req), .run_req(run_req), .tick(tick), .din(din), .q(q_cnt),
    .up(up), .dw(dw), .ld(ld), .ld_val(ld_val), .state(state),
    .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External counter driven by the strobes.
  always @(posedge clk) begin
    if (ld)      q_cnt <= ld_val;
    else if (up) q_cnt <= q_cnt + 16'h0001;
    else if (dw) q_cnt <= q_cnt - 16'h0001;
  end

  typedef struct {
    int          cyc;
    int          kind;   // 0 up, 1 dw, 2 ld
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int drop_cnt = 0;
  int strobe_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int k, input logic [15:0] v);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v;
    sb.push_back(e);
  endtask

  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [15:0] v);
    ld_req = 1'b1; din = v;
    push(cyc + 1, 2, v);
    go(1);
    ld_req = 1'b0;
    go(1);
    chk("load_q", q_cnt, v);
    chk("load_exit_state", state, 2'b00);
  endtask

  // Strobe monitor / scoreboard consumer.
  always @(negedge clk) begin
    int   k;
    exp_t e;
    if (greset_n) begin
      chk("onehot", ($countones({up, dw, ld}) <= 1), 1'b1);
      if (drop) drop_cnt++;
      if (up || dw || ld) begin
        k = up ? 0 : (dw ? 1 : 2);
        strobe_cnt++;
        $display("cyc %0d strobe %s q=%h ld_val=%h", cyc,
                 (k == 0) ? "up" : ((k == 1) ? "dw" : "ld"), q_cnt, ld_val);
        n_checks++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_strobe: observed kind %0d at cyc %0d expected none", k, cyc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("strobe_kind", k, e.kind);
          chk("strobe_cyc", cyc, e.cyc);
          if (e.kind == 2) chk("ld_val", ld_val, e.val);
        end
      end
    end
  end

  initial begin
    int d0;
    int s0;

    // Reset state
    go(2);
    chk("rst_up", up, 0);
    chk("rst_dw", dw, 0);
    chk("rst_ld", ld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_ld_val", ld_val, 16'h0000);
    chk("rst_state", state, 2'b00);
    greset_n = 1'b1;
    go(1);

    // Same-cycle up+dw at 0010: dw at n+1, up at n+3, no drop
    load(16'h0010);
    d0 = drop_cnt;
    up_req = 1'b1; dw_req = 1'b1;
    push(cyc + 1, 1, 16'h0); push(cyc + 3, 0, 16'h0);
    go(1);
    up_req = 1'b0; dw_req = 1'b0;
    chk("A_dw", dw, 1);
    go(1);
    chk("A_cooldown", {up, dw}, 2'b00);
    chk("A_busy_pend", busy, 1);
    go(1);
    chk("A_up", up, 1);
    go(2);
    chk("A_q", q_cnt, 16'h0010);
    chk("A_busy_idle", busy, 0);
    chk("A_nodrop", drop_cnt, d0);

    // Two up pulses around a cooldown: second dropped, one up strobe
    d0 = drop_cnt;
    dw_req = 1'b1;
    push(cyc + 1, 1, 16'h0);
    go(1);
    dw_req = 1'b0; up_req = 1'b1;
    go(1);
    chk("B_cool_noup", up, 0);
    push(cyc + 1, 0, 16'h0);
    go(1);
    up_req = 1'b0;
    chk("B_drop", drop, 1);
    chk("B_up", up, 1);
    go(3);
    chk("B_drop_cnt", drop_cnt, d0 + 1);
    chk("B_q", q_cnt, 16'h0010);

    // Load held 3 cycles with an up request in the first cycle
    ld_req = 1'b1; din = 16'h1234; up_req = 1'b1;
    push(cyc + 1, 2, 16'h1234); push(cyc + 2, 2, 16'h1234);
    push(cyc + 3, 2, 16'h1234); push(cyc + 5, 0, 16'h0);
    go(1);
    up_req = 1'b0;
    chk("C_state_load", state, 2'b11);
    go(2);
    chk("C_ld3", ld, 1);
    chk("C_ld_val", ld_val, 16'h1234);
    ld_req = 1'b0;
    go(1);
    chk("C_state_idle", state, 2'b00);
    chk("C_ld_off", ld, 0);
    go(1);
    chk("C_up_after", up, 1);
    go(2);
    chk("C_q", q_cnt, 16'h1235);

    // Run to top from FFF8, tick every 4 cycles
    load(16'hFFF8);
    run_req = 1'b1;
    go(1);
    chk("D_state_run", state, 2'b01);
    go(1);
    for (int i = 0; i < 6; i++) begin
      tick = 1'b1;
      if (i < 4) push(cyc + 1, 0, 16'h0);
      go(1);
      tick = 1'b0;
      go(3);
    end
    chk("D_state_top", state, 2'b10);
    chk("D_q_top", q_cnt, 16'hFFFC);
    up_req = 1'b1;
    push(cyc + 1, 0, 16'h0);
    go(1);
    up_req = 1'b0;
    go(2);
    chk("D_top_manual_q", q_cnt, 16'hFFFD);
    chk("D_still_top", state, 2'b10);
    run_req = 1'b0;
    go(1);
    chk("D_top_exit", state, 2'b00);

    // Boundary at FFFF / 0000
    load(16'hFFFF);
    d0 = drop_cnt;
`ifdef CNT_CTRL_SAT_EN
    up_req = 1'b1;
    go(1);
    up_req = 1'b0;
    chk("E_sat_up_drop", drop, 1);
    go(2);
    chk("E_sat_q_hi", q_cnt, 16'hFFFF);
    load(16'h0000);
    dw_req = 1'b1;
    go(1);
    dw_req = 1'b0;
    chk("E_sat_dw_drop", drop, 1);
    go(2);
    chk("E_sat_q_lo", q_cnt, 16'h0000);
    chk("E_sat_drop_cnt", drop_cnt, d0 + 2);
`else
    up_req = 1'b1;
    push(cyc + 1, 0, 16'h0);
    go(1);
    up_req = 1'b0;
    chk("E_wrap_up", up, 1);
    go(2);
    chk("E_wrap_q0", q_cnt, 16'h0000);
    dw_req = 1'b1;
    push(cyc + 1, 1, 16'h0);
    go(1);
    dw_req = 1'b0;
    chk("E_wrap_dw", dw, 1);
    go(2);
    chk("E_wrap_qf", q_cnt, 16'hFFFF);
    chk("E_wrap_nodrop", drop_cnt, d0);
`endif

    // Reset mid-RUN with an up request pending
    load(16'h0100);
    run_req = 1'b1;
    go(1);
    chk("F_state_run", state, 2'b01);
    dw_req = 1'b1;
    push(cyc + 1, 1, 16'h0);
    go(1);
    dw_req = 1'b0; up_req = 1'b1;
    go(1);
    up_req = 1'b0;
    chk("F_run_pend", state, 2'b01);
    chk("F_busy_pend", busy, 1);
    s0 = strobe_cnt;
    #2;
    greset_n = 1'b0;
    #1;
    chk("F_rst_up", up, 0);
    chk("F_rst_dw", dw, 0);
    chk("F_rst_ld", ld, 0);
    chk("F_rst_busy", busy, 0);
    chk("F_rst_drop", drop, 0);
    chk("F_rst_ld_val", ld_val, 16'h0000);
    chk("F_rst_state", state, 2'b00);
    run_req = 1'b0;
    go(2);
    greset_n = 1'b1;
    go(6);
    chk("F_no_strobe", strobe_cnt, s0);
    chk("F_idle", state, 2'b00);

    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
